// File: rtl/dl_event_logger_if.sv
//------------------------------------------------------------------------------
// Module : dl_event_logger_if
// Brief  : Read-side handshake of the deadlock/timeout event log FIFO.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dl_event_logger_if #(
   parameter int N_PROC = 5,
   parameter int CNT_W  = 16
);
   logic                      rd_en;
   logic                      rd_valid;
   logic [2*N_PROC+CNT_W:0]   rd_data;

   modport master (output rd_en, input rd_valid, input rd_data);
   modport slave  (input rd_en, output rd_valid, output rd_data);
endinterface

`default_nettype wire

// File: rtl/dl_event_logger.sv
//------------------------------------------------------------------------------
// Module : dl_event_logger
// Brief  : Confirms deadlocks, watches for stalls, logs both into a show-ahead FIFO.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dl_event_logger #(
   parameter int N_PROC  = 5,
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 16,
   parameter int CONFIRM = 4
) (
   input  wire logic                      clock,
   input  wire logic                      reset,
   input  wire logic                      dl_detect_in,
   input  wire logic [N_PROC-1:0]         dl_vec_in,
   input  wire logic [N_PROC-1:0]         origin_in,
   input  wire logic [N_PROC-1:0]         progress_in,
   input  wire logic [CNT_W-1:0]          timeout_lim,
   dl_event_logger_if.slave               rd,
   output logic [$clog2(DEPTH):0]         count,
   output logic                           overflow,
   output logic                           irq,
   output logic [CNT_W-1:0]               stall_cnt
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_EW = 2*N_PROC + 1 + CNT_W;
   localparam int c_CW = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
   localparam logic [c_CW-1:0] c_CONF_LAST = c_CW'(CONFIRM - 1);
   localparam logic [c_AW:0]   c_FULL      = (c_AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONFIRM = 2'd1,
      S_LATCHED = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [c_CW-1:0]    r_conf_cnt, w_conf_nxt;
   logic               w_dl_ev;

   logic [CNT_W-1:0]   r_ts;
   logic [CNT_W-1:0]   r_stall, w_stall_nxt;
   logic               r_to_fired;
   logic               r_to_pend;
   logic               w_any_prog;
   logic               w_to_ev;

   logic [c_EW-1:0]    r_mem [DEPTH];
   logic [c_AW-1:0]    r_wptr, r_rptr;
   logic [c_AW:0]      r_count;
   logic               r_overflow;
   logic               w_wr, w_full, w_pop, w_push;
   logic [c_EW-1:0]    w_entry;

   // Detect FSM: the CONFIRM-th consecutive high cycle is the event cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_conf_nxt  = r_conf_cnt;
      w_dl_ev     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (dl_detect_in) begin
               if (CONFIRM == 1) begin
                  w_dl_ev     = 1'b1;
                  w_state_nxt = S_LATCHED;
               end else begin
                  w_state_nxt = S_CONFIRM;
                  w_conf_nxt  = c_CW'(1);
               end
            end
         end
         S_CONFIRM: begin
            if (!dl_detect_in) begin
               w_state_nxt = S_IDLE;
               w_conf_nxt  = '0;
            end else if (r_conf_cnt == c_CONF_LAST) begin
               w_dl_ev     = 1'b1;
               w_state_nxt = S_LATCHED;
               w_conf_nxt  = '0;
            end else begin
               w_conf_nxt  = r_conf_cnt + c_CW'(1);
            end
         end
         S_LATCHED: begin
            if (!dl_detect_in) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_conf_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_conf_cnt <= w_conf_nxt;
      end
   end

   // Watchdog: the fired flag limits each stall episode to one timeout event.
   always_comb begin
      w_any_prog  = |progress_in;
      w_stall_nxt = r_stall;
      if (w_any_prog)                w_stall_nxt = '0;
      else if (r_stall < timeout_lim) w_stall_nxt = r_stall + CNT_W'(1);
      w_to_ev = (timeout_lim != '0) && (r_stall == timeout_lim) && !r_to_fired;
   end

   always_comb begin
      w_wr    = w_dl_ev | r_to_pend | w_to_ev;
      w_entry = w_dl_ev ? {1'b0, origin_in, dl_vec_in, r_ts}
                        : {1'b1, {N_PROC{1'b0}}, dl_vec_in, r_ts};
      w_full  = (r_count == c_FULL);
      w_pop   = rd.rd_en && (r_count != '0);
      w_push  = w_wr && (!w_full || w_pop);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_ts       <= '0;
         r_stall    <= '0;
         r_to_fired <= 1'b0;
         r_to_pend  <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_ts    <= r_ts + CNT_W'(1);
         r_stall <= w_stall_nxt;
         if (w_any_prog)   r_to_fired <= 1'b0;
         else if (w_to_ev) r_to_fired <= 1'b1;
         // A timeout colliding with a deadlock is deferred by one cycle.
         r_to_pend <= w_dl_ev && (w_to_ev || r_to_pend);
         if (w_push) r_wptr <= r_wptr + c_AW'(1);
         if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (c_AW+1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (c_AW+1)'(1);
         if (w_wr && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wptr] <= w_entry;
   end

   assign rd.rd_valid = (r_count != '0);
   assign rd.rd_data  = (r_count != '0) ? r_mem[r_rptr] : '0;
   assign count       = r_count;
   assign overflow    = r_overflow;
   assign irq         = (r_count != '0);
   assign stall_cnt   = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_dl_event_logger.sv
//------------------------------------------------------------------------------
// Module : tb_dl_event_logger
// Brief  : Directed self-checking bench for dl_event_logger.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dl_event_logger;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        dl_detect_in = 1'b0;
   logic [4:0]  dl_vec_in = '0;
   logic [4:0]  origin_in = '0;
   logic [4:0]  progress_in = '0;
   logic [15:0] timeout_lim = '0;
   logic [3:0]  count;
   logic        overflow, irq;
   logic [15:0] stall_cnt;

   logic [15:0] ts_m = '0;
   logic [26:0] exp_e [0:9];
   logic [26:0] exp_d;
   logic [15:0] t;
   int checks = 0;
   int failures = 0;

   dl_event_logger_if #(.N_PROC(5), .CNT_W(16)) rd_if ();

   dl_event_logger #(.N_PROC(5), .DEPTH(8), .CNT_W(16), .CONFIRM(4)) dut (
      .clock(clock), .reset(reset), .dl_detect_in(dl_detect_in),
      .dl_vec_in(dl_vec_in), .origin_in(origin_in), .progress_in(progress_in),
      .timeout_lim(timeout_lim), .rd(rd_if), .count(count),
      .overflow(overflow), .irq(irq), .stall_cnt(stall_cnt)
   );

   always #5 clock = ~clock;

   // ts_m tracks the timestamp value in force during the current cycle.
   task automatic tick();
      @(posedge clock);
      if (reset) ts_m = ts_m + 16'd1;
      else       ts_m = '0;
      #1;
   endtask

   task automatic make_dl(input logic [4:0] o, input logic [4:0] v,
                          input bit pop_on_ev, output logic [15:0] ev_ts);
      dl_detect_in = 1'b1; origin_in = o; dl_vec_in = v;
      repeat (3) tick();
      ev_ts = ts_m;
      rd_if.rd_en = pop_on_ev;
      tick();
      rd_if.rd_en = 1'b0;
      dl_detect_in = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      checks++; if (rd_if.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b want=0", rd_if.rd_valid); end
      checks++; if (rd_if.rd_data !== 27'd0) begin failures++; $display("FAIL reset_rd_data got=%h want=0", rd_if.rd_data); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b want=0", irq); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
      checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
   endtask

   task automatic test_confirm();
      dl_detect_in = 1'b1;
      repeat (3) tick();
      dl_detect_in = 1'b0;
      repeat (3) tick();
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL short_detect_count got=%0d want=0", count); end
      origin_in = 5'b00100; dl_vec_in = 5'b00110; dl_detect_in = 1'b1;
      t = '0;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) t = ts_m;
         tick();
         if (i == 2) begin
            checks++; if (rd_if.rd_valid !== 1'b0) begin failures++; $display("FAIL confirm_early_valid got=%0b want=0", rd_if.rd_valid); end
         end
         if (i == 3) begin
            checks++; if (rd_if.rd_valid !== 1'b1) begin failures++; $display("FAIL confirm_valid_latency got=%0b want=1", rd_if.rd_valid); end
         end
      end
      dl_detect_in = 1'b0;
      tick();
      exp_d = {1'b0, 5'b00100, 5'b00110, t};
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL confirm_count got=%0d want=1", count); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL confirm_irq got=%0b want=1", irq); end
      checks++; if (rd_if.rd_data !== exp_d) begin failures++; $display("FAIL confirm_entry got=%h want=%h", rd_if.rd_data, exp_d); end
      rd_if.rd_en = 1'b1; tick(); rd_if.rd_en = 1'b0;
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL confirm_pop_count got=%0d want=0", count); end
   endtask

   task automatic test_watchdog();
      dl_vec_in = 5'b01001;
      timeout_lim = 16'd10;
      repeat (10) tick();
      checks++; if (stall_cnt !== 16'd10) begin failures++; $display("FAIL wd_reach got=%0d want=10", stall_cnt); end
      t = ts_m;
      tick();
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL wd_entry_count got=%0d want=1", count); end
      repeat (5) tick();
      checks++; if (stall_cnt !== 16'd10) begin failures++; $display("FAIL wd_hold got=%0d want=10", stall_cnt); end
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL wd_once got=%0d want=1", count); end
      exp_d = {1'b1, 5'b00000, 5'b01001, t};
      checks++; if (rd_if.rd_data !== exp_d) begin failures++; $display("FAIL wd_entry got=%h want=%h", rd_if.rd_data, exp_d); end
      rd_if.rd_en = 1'b1; tick(); rd_if.rd_en = 1'b0;
      progress_in = 5'b00001; tick(); progress_in = '0;
      repeat (9) tick();
      checks++; if (stall_cnt !== 16'd9) begin failures++; $display("FAIL wd_nine got=%0d want=9", stall_cnt); end
      progress_in = 5'b10000; tick(); progress_in = '0;
      timeout_lim = 16'd0;
      checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL wd_progress_clear got=%0d want=0", stall_cnt); end
      repeat (3) tick();
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL wd_no_entry got=%0d want=0", count); end
   endtask

   task automatic test_collision();
      timeout_lim = 16'd3;
      origin_in = 5'b00010; dl_vec_in = 5'b00011; dl_detect_in = 1'b1;
      repeat (3) tick();
      t = ts_m;
      repeat (2) tick();
      checks++; if (count !== 4'd2) begin failures++; $display("FAIL coll_count got=%0d want=2", count); end
      exp_d = {1'b0, 5'b00010, 5'b00011, t};
      checks++; if (rd_if.rd_data !== exp_d) begin failures++; $display("FAIL coll_head got=%h want=%h", rd_if.rd_data, exp_d); end
      rd_if.rd_en = 1'b1; tick(); rd_if.rd_en = 1'b0;
      exp_d = {1'b1, 5'b00000, 5'b00011, t + 16'd1};
      checks++; if (rd_if.rd_data !== exp_d) begin failures++; $display("FAIL coll_second got=%h want=%h", rd_if.rd_data, exp_d); end
      rd_if.rd_en = 1'b1; tick(); rd_if.rd_en = 1'b0;
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL coll_drain got=%0d want=0", count); end
      dl_detect_in = 1'b0; timeout_lim = 16'd0; progress_in = 5'b00100;
      tick();
      progress_in = '0;
      tick();
   endtask

   task automatic test_overflow();
      logic [15:0] et;
      logic [4:0]  o, v;
      for (int i = 0; i < 9; i++) begin
         o = 5'd1 << (i % 5);
         v = 5'(i + 1);
         make_dl(o, v, 1'b0, et);
         exp_e[i] = {1'b0, o, v, et};
         if (i == 7) begin
            checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_at_full got=%0b want=0", overflow); end
         end
      end
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d want=8", count); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
      checks++; if (rd_if.rd_data !== exp_e[0]) begin failures++; $display("FAIL ovf_head got=%h want=%h", rd_if.rd_data, exp_e[0]); end
      make_dl(5'b11000, 5'b10101, 1'b1, et);
      exp_e[9] = {1'b0, 5'b11000, 5'b10101, et};
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_popwr_count got=%0d want=8", count); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL full_popwr_ovf got=%0b want=1", overflow); end
   endtask

   task automatic test_drain();
      int idx;
      rd_if.rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         idx = (i < 7) ? i + 1 : 9;
         checks++; if (rd_if.rd_data !== exp_e[idx]) begin failures++; $display("FAIL drain_entry%0d got=%h want=%h", i, rd_if.rd_data, exp_e[idx]); end
         tick();
      end
      checks++; if (rd_if.rd_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0b want=0", rd_if.rd_valid); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL drain_irq got=%0b want=0", irq); end
      repeat (2) tick();
      rd_if.rd_en = 1'b0;
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL empty_pop_count got=%0d want=0", count); end
      checks++; if (rd_if.rd_data !== 27'd0) begin failures++; $display("FAIL empty_data got=%h want=0", rd_if.rd_data); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b want=1", overflow); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] et;
      timeout_lim = 16'd20;
      for (int i = 0; i < 3; i++) make_dl(5'b00001, 5'b00111, 1'b0, et);
      dl_detect_in = 1'b1;
      repeat (2) tick();
      checks++; if (count !== 4'd3) begin failures++; $display("FAIL pre_reset_count got=%0d want=3", count); end
      checks++; if (stall_cnt !== 16'd17) begin failures++; $display("FAIL pre_reset_stall got=%0d want=17", stall_cnt); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      timeout_lim = 16'd0;
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL mid_reset_count got=%0d want=0", count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mid_reset_ovf got=%0b want=0", overflow); end
      checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL mid_reset_stall got=%0d want=0", stall_cnt); end
      origin_in = 5'b01000; dl_vec_in = 5'b11000;
      repeat (3) tick();
      t = ts_m;
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL post_reset_early got=%0d want=0", count); end
      tick();
      exp_d = {1'b0, 5'b01000, 5'b11000, t};
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL post_reset_count got=%0d want=1", count); end
      checks++; if (rd_if.rd_data !== exp_d) begin failures++; $display("FAIL post_reset_entry got=%h want=%h", rd_if.rd_data, exp_d); end
      dl_detect_in = 1'b0;
      tick();
   endtask

   initial begin
      rd_if.rd_en = 1'b0;
      test_reset();
      test_confirm();
      test_watchdog();
      test_collision();
      test_overflow();
      test_drain();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
